// File: rtl/control_unit.sv
// Fetch/decode sequencer for the register-file/ALU datapath: fetch, one-cycle execute, halt.
// Optional single-step pause between instructions when CU_SINGLE_STEP_EN is defined.
module control_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [23:0]     imem_data,
    input  logic            imem_valid,
    output logic            alu_en,
    output logic [3:0]      alu_opcode,
    output logic [7:0]      imm_value,
    output logic [3:0]      write_addr,
    output logic [3:0]      ra_addr,
    output logic [3:0]      rb_addr,
    output logic            write_en,
    output logic            imm_flag,
    input  logic            alu_zero,
    input  logic            alu_carry,
    output logic            halted,
    output logic            illegal
);

    localparam logic [3:0] CLS_NOP  = 4'd0;
    localparam logic [3:0] CLS_ALUR = 4'd1;
    localparam logic [3:0] CLS_ALUI = 4'd2;
    localparam logic [3:0] CLS_LDI  = 4'd3;
    localparam logic [3:0] CLS_JMP  = 4'd4;
    localparam logic [3:0] CLS_BZ   = 4'd5;
    localparam logic [3:0] CLS_BC   = 4'd6;
    localparam logic [3:0] CLS_HALT = 4'd7;

`ifdef CU_SINGLE_STEP_EN
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_PAUSE} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
`endif

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [23:0]     ir_reg;
    logic            z_reg;
    logic            c_reg;
    logic            illegal_reg;

    logic [3:0]      cls;
    logic            is_exec;
    logic            is_alu;
    logic            branch_taken;
    logic [PC_W-1:0] target_pc;

    assign cls       = ir_reg[23:20];
    assign is_exec   = (state_reg == S_EXEC);
    assign is_alu    = (cls == CLS_ALUR) || (cls == CLS_ALUI);
    assign target_pc = PC_W'(ir_reg[7:0]);

    // Branches look only at the flags captured by the last ALU instruction.
    assign branch_taken = (cls == CLS_JMP) ||
                          ((cls == CLS_BZ) && z_reg) ||
                          ((cls == CLS_BC) && c_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            z_reg       <= 1'b0;
            c_reg       <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_reg    <= imem_data;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_alu) begin
                        z_reg <= alu_zero;
                        c_reg <= alu_carry;
                    end
                    if (cls[3]) begin
                        illegal_reg <= 1'b1;
                    end
                    if (cls == CLS_HALT) begin
                        state_reg <= S_HALT;
                    end else begin
                        pc_reg <= branch_taken ? target_pc : pc_reg + PC_W'(1);
`ifdef CU_SINGLE_STEP_EN
                        state_reg <= S_PAUSE;
`else
                        state_reg <= S_FETCH;
`endif
                    end
                end
`ifdef CU_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        state_reg <= S_FETCH;
                    end
                end
`endif
                default: begin
                    state_reg <= S_HALT;
                end
            endcase
        end
    end

    // Gating imem_rd with rst_n keeps the fetch request low for the whole reset.
    assign imem_addr  = pc_reg;
    assign imem_rd    = rst_n && (state_reg == S_FETCH);
    assign halted     = (state_reg == S_HALT);
    assign illegal    = illegal_reg;

    assign alu_opcode = is_exec ? ir_reg[19:16] : 4'd0;
    assign write_addr = is_exec ? ir_reg[15:12] : 4'd0;
    assign ra_addr    = is_exec ? ir_reg[11:8]  : 4'd0;
    assign rb_addr    = is_exec ? ir_reg[7:4]   : 4'd0;
    assign imm_value  = is_exec ? ir_reg[7:0]   : 8'd0;
    assign alu_en     = is_exec && is_alu;
    assign imm_flag   = is_exec && (cls == CLS_ALUI);
    assign write_en   = is_exec && (is_alu || (cls == CLS_LDI));

    logic unused_nop;
    assign unused_nop = (cls == CLS_NOP);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: zero-wait memory model, branches, stalls, wrap, illegal, reset.
// Builds the single-step scenario instead when CU_SINGLE_STEP_EN is defined.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [23:0] imem_data;
    logic        imem_valid;
    logic        alu_en;
    logic [3:0]  alu_opcode;
    logic [7:0]  imm_value;
    logic [3:0]  write_addr;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic        write_en;
    logic        imm_flag;
    logic        alu_zero;
    logic        alu_carry;
    logic        halted;
    logic        illegal;
`ifdef CU_SINGLE_STEP_EN
    logic        step;
`endif

    logic [23:0] mem [256];
    int checks;
    int errors;

    assign imem_data = mem[imem_addr];

    control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CU_SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .alu_en     (alu_en),
        .alu_opcode (alu_opcode),
        .imm_value  (imm_value),
        .write_addr (write_addr),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .write_en   (write_en),
        .imm_flag   (imm_flag),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 24'h000000;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        imem_valid = 1'b1;
        alu_zero   = 1'b0;
        alu_carry  = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step       = 1'b0;
`endif
        clear_mem();
        #2;
        check("rst_addr",    32'(imem_addr), 32'h00);
        check("rst_rd",      32'(imem_rd),   32'h0);
        check("rst_we",      32'(write_en),  32'h0);
        check("rst_halted",  32'(halted),    32'h0);
        check("rst_illegal", 32'(illegal),   32'h0);

`ifdef CU_SINGLE_STEP_EN
        mem[0] = 24'h301005;
        mem[1] = 24'h302003;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ss_fetch0_rd", 32'(imem_rd), 32'h1);
        nc();
        check("ss_exec0_wa", {write_en, write_addr}, {1'b1, 4'd1});
        for (int i = 0; i < 10; i++) begin
            nc();
            check("ss_pause_rd",   32'(imem_rd),   32'h0);
            check("ss_pause_we",   32'(write_en),  32'h0);
            check("ss_pause_addr", 32'(imem_addr), 32'h01);
        end
        step = 1'b1;
        nc();
        step = 1'b0;
        check("ss_step_rd", 32'(imem_rd), 32'h1);
        nc();
        check("ss_exec1_wa", {write_en, write_addr}, {1'b1, 4'd2});
        nc();
        check("ss_pause2_rd",     32'(imem_rd),   32'h0);
        check("ss_pause2_halted", 32'(halted),    32'h0);
        check("ss_pause2_addr",   32'(imem_addr), 32'h02);
`else
        // LDI r1,5 / LDI r2,3 / ALUR r3=r1+r2 / HALT
        mem[0] = 24'h301005;
        mem[1] = 24'h302003;
        mem[2] = 24'h103120;
        mem[3] = 24'h700000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("p1_fetch0_rd", 32'(imem_rd), 32'h1);
        nc();
        check("p1_exec0", {write_en, write_addr, alu_en, imm_value}, {1'b1, 4'd1, 1'b0, 8'h05});
        nc();
        check("p1_fetch1", {imem_rd, write_en, imem_addr}, {1'b1, 1'b0, 8'h01});
        nc();
        check("p1_exec1", {write_en, write_addr, imm_value}, {1'b1, 4'd2, 8'h03});
        nc();
        nc();
        check("p1_exec2", {write_en, write_addr, alu_en, ra_addr, rb_addr, imm_flag},
                          {1'b1, 4'd3, 1'b1, 4'd1, 4'd2, 1'b0});
        nc();
        nc();
        check("p1_exec3_we", 32'(write_en), 32'h0);
        nc();
        check("p1_halt", {halted, imem_rd, write_en, imem_addr}, {1'b1, 1'b0, 1'b0, 8'h03});
        nc();
        check("p1_halt_hold", {halted, imem_addr}, {1'b1, 8'h03});

        // ALUI sets Z, BZ taken; ALUI clears Z, BZ falls through despite live zero=1
        rst_n = 1'b0;
        #1;
        check("p2_async_rst", {halted, imem_addr}, {1'b0, 8'h00});
        clear_mem();
        mem[8'h00] = 24'h214107;
        mem[8'h01] = 24'h500020;
        mem[8'h20] = 24'h214107;
        mem[8'h21] = 24'h500040;
        mem[8'h22] = 24'h700000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nc();
        check("p2_alui", {write_en, alu_en, imm_flag, alu_opcode, write_addr, ra_addr, imm_value},
                         {1'b1, 1'b1, 1'b1, 4'd1, 4'd4, 4'd1, 8'h07});
        alu_zero = 1'b1;
        nc();
        alu_zero = 1'b0;
        nc();
        check("p2_bz_we", 32'(write_en), 32'h0);
        nc();
        check("p2_bz_taken", 32'(imem_addr), 32'h20);
        nc();
        nc();
        nc();
        alu_zero = 1'b1;
        nc();
        check("p2_bz_fallthru", 32'(imem_addr), 32'h22);
        alu_zero = 1'b0;

        // Memory stall, then JMP to 0xFE: illegal word, NOP at 0xFF, wrap to 0
        rst_n = 1'b0;
        clear_mem();
        mem[8'h00] = 24'h305011;
        mem[8'h01] = 24'h4000FE;
        mem[8'hFE] = 24'hA5F456;
        mem[8'hFF] = 24'h000000;
        imem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("p3_stall", {imem_rd, imem_addr, write_en}, {1'b1, 8'h00, 1'b0});
            if (i < 4) nc();
        end
        imem_valid = 1'b1;
        nc();
        check("p3_after_valid", {write_en, write_addr, imm_value}, {1'b1, 4'd5, 8'h11});
        nc();
        nc();
        nc();
        check("p3_jmp", 32'(imem_addr), 32'hFE);
        nc();
        check("p3_illegal_exec", {write_en, illegal}, {1'b0, 1'b0});
        nc();
        check("p3_illegal_set", {illegal, imem_addr}, {1'b1, 8'hFF});
        nc();
        nc();
        check("p3_wrap", {illegal, imem_addr}, {1'b1, 8'h00});
        nc();
        nc();
        nc();
        nc();
        check("p3_fetch_fe", {imem_rd, imem_addr}, {1'b1, 8'hFE});

        // Reset mid-fetch must clear outputs without a clock edge
        rst_n = 1'b0;
        #1;
        check("p4_rst_fetch", {imem_rd, imem_addr, illegal, halted}, {1'b0, 8'h00, 1'b0, 1'b0});
        clear_mem();
        mem[8'h00] = 24'h214107;
        mem[8'h01] = 24'h306022;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nc();
        alu_carry = 1'b1;
        nc();
        alu_carry = 1'b0;
        nc();
        check("p4_ldi_exec", {write_en, write_addr}, {1'b1, 4'd6});
        rst_n = 1'b0;
        #1;
        check("p4_rst_exec", {write_en, write_addr, imm_value, imem_addr}, {1'b0, 4'd0, 8'h00, 8'h00});
        mem[8'h00] = 24'h600030;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nc();
        check("p4_bc_exec_we", 32'(write_en), 32'h0);
        nc();
        check("p4_bc_fallthru", 32'(imem_addr), 32'h01);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction fetch/decode sequencer that sits directly upstream of the register-file/ALU datapath.
- Fetches 24-bit instructions from an instruction memory port with a valid handshake, decodes them, and drives the datapath control inputs for one execute cycle per instruction.
- Registers the datapath's zero/carry flags and uses them for conditional branches.

Parameters:
- PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  PC_W  fetch address (the current PC).
- imem_rd  out  1  fetch request; held high in FETCH until imem_valid.
- imem_data  in  24  instruction word; sampled only when imem_rd && imem_valid.
- imem_valid  in  1  memory response valid; ignored when imem_rd=0.
- alu_en  out  1  1 = datapath writes the ALU result; 0 = it writes imm_value.
- alu_opcode  out  4  ALU operation.
- imm_value  out  8  immediate operand / load value.
- write_addr  out  4  destination register.
- ra_addr  out  4  source register A.
- rb_addr  out  4  source register B.
- write_en  out  1  register write strobe.
- imm_flag  out  1  1 = ALU B operand comes from imm_value.
- alu_zero  in  1  datapath zero flag.
- alu_carry  in  1  datapath carry flag.
- halted  out  1  high while in HALT.
- illegal  out  1  sticky; set on an undefined class.

Behaviour:
- Instruction fields: [23:20] class, [19:16] alu_op, [15:12] rd, [11:8] ra, [7:4] rb, [7:0] imm (imm overlaps rb).
- Classes:
  - 0 NOP.
  - 1 ALUR: rd = ra op rb.
  - 2 ALUI: rd = ra op imm.
  - 3 LDI: rd = imm.
  - 4 JMP: pc = imm[PC_W-1:0].
  - 5 BZ: branch to imm if Z flag is set.
  - 6 BC: branch to imm if C flag is set.
  - 7 HALT.
  - 8-15 illegal: executed as NOP and sets illegal.
- States: FETCH, EXEC, HALT (plus PAUSE under the option). Reset state is FETCH.
- FETCH:
  - imem_rd=1, imem_addr=pc.
  - On imem_valid: latch imem_data into ir, go to EXEC.
  - Wait indefinitely if imem_valid stays 0.
- EXEC (exactly one cycle): datapath outputs are decoded combinationally from ir.
  - ALUR: alu_en=1, imm_flag=0, write_en=1.
  - ALUI: alu_en=1, imm_flag=1, write_en=1.
  - LDI: alu_en=0, imm_flag=0, write_en=1.
  - All other classes: write_en=0.
  - Addresses, alu_opcode and imm_value always reflect ir fields in EXEC.
  - For ALUR/ALUI only: Z <= alu_zero and C <= alu_carry at the end of EXEC. Other classes leave Z/C unchanged.
  - PC update: pc <= imm for JMP, or for BZ/BC when the condition holds; otherwise pc <= pc+1 with wrap.
  - Next state: HALT for class 7, else FETCH.
- Outside EXEC: write_en=0, alu_en=0, imm_flag=0; all address, opcode and immediate outputs are 0.
- Throughput: minimum 2 cycles per instruction (1 fetch with zero-wait memory + 1 exec).
- HALT:
  - imem_rd=0, halted=1, no writes.
  - Exited only by reset.
  - HALT does not advance the PC (pc holds the HALT address).
- Branches use Z/C as registered by the most recent ALU instruction, never the live flags.
- Branch to the current PC is legal and loops.
- Writes to r0 are passed through unchanged; the datapath masks them.
- Reset (asynchronous, at any point including mid-fetch):
  - pc=RESET_PC, ir=0, Z=C=0, illegal=0, halted=0.
  - All outputs 0 except imem_addr=RESET_PC.
  - State=FETCH.
- A pending fetch is abandoned by reset; an imem_valid arriving during reset is ignored.
- PC wrap: pc = 2^PC_W-1 followed by a non-branch gives pc=0.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - After every EXEC that would go to FETCH, the block enters PAUSE instead.
  - PAUSE: all datapath outputs 0, imem_rd=0, halted=0.
  - A single-cycle step=1 pulse in PAUSE moves to FETCH.
  - step is ignored in every other state.
- Undefined: no step port, no PAUSE state; EXEC goes directly to FETCH.

Test Plan:
- Zero-wait memory; program LDI r1,0x05 / LDI r2,0x03 / ALUR r3=r1 op(ADD) r2 / HALT -> write_en pulses with write_addr 1, 2, 3 in successive EXEC cycles; the third EXEC shows alu_en=1, ra=1, rb=2; halted=1 after 8 cycles; imem_addr stops at 3.
- ALUI with alu_zero=1 driven in EXEC, then BZ 0x20 -> next imem_addr=0x20. Repeat with alu_zero=0 -> next imem_addr = BZ address + 1.
- imem_valid held low 5 cycles in FETCH -> imem_rd stays high, imem_addr is stable, write_en=0 throughout; the instruction executes on the cycle after valid.
- pc=0xFF, NOP -> next imem_addr=0x00. Class 0xA word -> illegal=1 and stays set; no write_en; pc advances.
- Assert rst_n=0 mid-FETCH and mid-EXEC -> outputs clear immediately without a clock edge; after release imem_addr=RESET_PC, Z=C=0 (a BC at address 0 falls through to 1).
- With CU_SINGLE_STEP_EN: after each instruction the block stays in PAUSE with imem_rd=0 for 10 cycles; a one-cycle step pulse causes exactly one fetch and execute.
